// File: rtl/cnn_upsamp_2x_new_pkg.sv
// Shared definitions for the 2x nearest-neighbour upsampler.
//   state_e        : top-level sequencing states (FILL / REPLAY)
//   UPS_CNT_WIDTH  : default width of the column/row counters
//   addr_width()   : row-buffer address width for a given depth
package cnn_upsamp_2x_new_pkg;

    typedef enum logic {
        ST_FILL   = 1'b0,  // accept a pixel, emit it twice
        ST_REPLAY = 1'b1   // re-emit the stored row for the second output line
    } state_e;

    localparam int UPS_CNT_WIDTH = 4;

    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/upsamp_row_buffer_new.sv
// Single-row pixel store for the 2x upsampler.
//   clk      : clock
//   wr_en    : write wr_data to wr_addr on this edge
//   wr_addr  : write column
//   wr_data  : pixel to store
//   rd_addr  : read column, sampled on the edge
//   rd_data  : registered read data (one-cycle read latency)
module upsamp_row_buffer_new #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    // NOTE: the array and its read register carry no reset; every entry is
    // written before it is read back, so clearing it would only cost logic.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        rd_data_q <= mem_q[rd_addr];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/cnn_upsamp_2x_new.sv
// 2x nearest-neighbour upsampler for raster-order pixel streams.
// Each input row of IMAGE_WIDTH pixels produces two output rows of
// 2*IMAGE_WIDTH pixels: the first while the row is being accepted (each
// pixel twice), the second replayed from the row buffer.
//   clk        : clock, rising edge
//   reset      : asynchronous, active-low
//   valid_in   : pxl_in is valid
//   pxl_in     : input pixel
//   ready_out  : pixel accepted when valid_in && ready_out
//   pxl_out    : upsampled pixel, holds when valid_out=0
//   valid_out  : pxl_out is valid
//   frame_done : pulse with the last output pixel of a frame
module cnn_upsamp_2x_new
    import cnn_upsamp_2x_new_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int IMAGE_WIDTH  = 8,
    parameter int IMAGE_HEIGHT = 8,
    parameter int CNT_WIDTH    = UPS_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] pxl_in,
    output logic                  ready_out,
    output logic [DATA_WIDTH-1:0] pxl_out,
    output logic                  valid_out,
    output logic                  frame_done
);

    localparam int                   AW       = addr_width(IMAGE_WIDTH);
    localparam logic [CNT_WIDTH-1:0] COL_LAST = CNT_WIDTH'(IMAGE_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] ROW_LAST = CNT_WIDTH'(IMAGE_HEIGHT - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    state_e                state_q, state_d;
    logic                  phase_q, phase_d;
    logic [CNT_WIDTH-1:0]  col_q, col_d;
    logic [CNT_WIDTH-1:0]  row_q, row_d;
    logic [DATA_WIDTH-1:0] pxl_out_q, pxl_out_d;
    logic                  valid_out_q, valid_out_d;
    logic                  frame_done_q, frame_done_d;
    logic                  run_q;

    logic                  accept;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] rd_data;

    // run_q keeps ready_out low while reset is held and for the release
    // cycle, even though the state already decodes as FILL/P=0.
    assign ready_out = run_q && (state_q == ST_FILL) && !phase_q;
    assign accept    = valid_in && ready_out;

    // NOTE: every signal assigned here gets a default first so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        col_d        = col_q;
        row_d        = row_q;
        pxl_out_d    = pxl_out_q;
        valid_out_d  = 1'b0;
        frame_done_d = 1'b0;
        wr_en        = 1'b0;

        case (state_q)
            ST_FILL: begin
                if (!phase_q) begin
                    if (accept) begin
                        wr_en       = 1'b1;
                        pxl_out_d   = pxl_in;
                        valid_out_d = 1'b1;
                        phase_d     = 1'b1;
                    end
                end else begin
                    // pxl_out_q still holds the accepted pixel: emit it again.
                    valid_out_d = 1'b1;
                    phase_d     = 1'b0;
                    if (col_q == COL_LAST) begin
                        col_d   = '0;
                        state_d = ST_REPLAY;
                    end else begin
                        col_d = col_q + CNT_ONE;
                    end
                end
            end

            ST_REPLAY: begin
                // The buffer is read with col_d, so rd_data already holds
                // buffer[col_q] in this cycle; phase selects first/second copy.
                pxl_out_d   = rd_data;
                valid_out_d = 1'b1;
                phase_d     = !phase_q;
                if (phase_q) begin
                    if (col_q == COL_LAST) begin
                        col_d        = '0;
                        state_d      = ST_FILL;
                        frame_done_d = (row_q == ROW_LAST);
                        row_d        = (row_q == ROW_LAST) ? '0 : row_q + CNT_ONE;
                    end else begin
                        col_d = col_q + CNT_ONE;
                    end
                end
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples values from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_FILL;
            phase_q      <= 1'b0;
            col_q        <= '0;
            row_q        <= '0;
            pxl_out_q    <= '0;
            valid_out_q  <= 1'b0;
            frame_done_q <= 1'b0;
            run_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            col_q        <= col_d;
            row_q        <= row_d;
            pxl_out_q    <= pxl_out_d;
            valid_out_q  <= valid_out_d;
            frame_done_q <= frame_done_d;
            run_q        <= 1'b1;
        end
    end

    upsamp_row_buffer_new #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (IMAGE_WIDTH),
        .ADDR_WIDTH (AW)
    ) u_row_buffer (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (col_q[AW-1:0]),
        .wr_data (pxl_in),
        .rd_addr (col_d[AW-1:0]),
        .rd_data (rd_data)
    );

    assign pxl_out    = pxl_out_q;
    assign valid_out  = valid_out_q;
    assign frame_done = frame_done_q;

endmodule
